phy_width_ctrl: RTL and testbench
=================================

PHY_WIDTH_CTRL -- requirements
Module: phy_width_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 16, the number of locked cycles PCLK stays gated after a divider switch (range 1..255).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum number of DRAIN cycles spent waiting for TX_Idle (range 1..255).
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port Width_Req, input, 1 bit: single-cycle width-change request strobe.
REQ-006 The block SHALL have port Req_Width, input, 6 bits: requested bus width, sampled with Width_Req.
REQ-007 The block SHALL have port PLL_Locked, input, 1 bit: Bit_CLK PLL lock status.
REQ-008 The block SHALL have port TX_Idle, input, 1 bit: TX datapath has no word in flight.
REQ-009 The block SHALL have port DataBusWidth, output, 6 bits: current configured width (8, 16 or 32).
REQ-010 The block SHALL have port Div_Sel, output, 2 bits: PCLK divider select (00 = /1 for width 8, 01 = /2 for 16, 10 = /4 for 32).
REQ-011 The block SHALL have port Gate_En, output, 1 bit: PCLK gate enable (1 = PCLK running).
REQ-012 The block SHALL have port Width_Ack, output, 1 bit: one-cycle pulse on successful completion.
REQ-013 The block SHALL have port Width_Err, output, 1 bit: one-cycle pulse on a rejected or timed-out request.
REQ-014 The block SHALL have port Busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, DRAIN, GATE and SETTLE; all outputs SHALL be registered.
REQ-016 In IDLE with Width_Req=1 and Req_Width not in {8,16,32}, or with PLL_Locked=0, the block SHALL pulse Width_Err in the next cycle and stay in IDLE with no output change.
REQ-017 In IDLE with a valid Req_Width equal to DataBusWidth, the block SHALL pulse Width_Ack in the next cycle, stay in IDLE and keep Gate_En=1.
REQ-018 In IDLE with a valid, different Req_Width, the block SHALL latch it and enter DRAIN next cycle with the timeout counter cleared.
REQ-019 In DRAIN with TX_Idle=1, the block SHALL go to GATE and drive Gate_En=0 from that edge.
REQ-020 In DRAIN with TX_Idle=0, the timeout counter SHALL increment; on reaching TIMEOUT_CYCLES the block SHALL return to IDLE, pulse Width_Err, and leave width, Div_Sel and Gate_En=1 unchanged.
REQ-021 Leaving GATE (one cycle), the block SHALL load DataBusWidth and the matching Div_Sel from the latched request, clear the settle counter and enter SETTLE.
REQ-022 In SETTLE the settle counter SHALL increment only while PLL_Locked=1 and SHALL clear to 0 in any cycle PLL_Locked=0.
REQ-023 When the settle counter reaches SETTLE_CYCLES, the block SHALL enter IDLE, set Gate_En=1 and pulse Width_Ack, all on the same edge.
REQ-024 With TX_Idle=1 and PLL_Locked=1 throughout, Width_Ack SHALL rise exactly SETTLE_CYCLES+3 cycles after the request cycle, and Gate_En SHALL be low for exactly SETTLE_CYCLES+1 cycles.
REQ-025 Width_Req while Busy=1 SHALL be ignored: no ack, no error, no queuing.
REQ-026 TX_Idle changes during GATE or SETTLE SHALL be ignored.
REQ-027 Width_Ack and Width_Err SHALL never be high in the same cycle.

Reset
REQ-028 On Reset=1 at a rising edge, the block SHALL set state IDLE, DataBusWidth=8, Div_Sel=00, Gate_En=1, Width_Ack=0, Width_Err=0, Busy=0 and both counters to 0.
REQ-029 Reset SHALL override any in-progress sequence, including mid-SETTLE, with no Ack or Err pulse.

Verification
REQ-030 Reset, then Width_Req with Req_Width=16, TX_Idle=1, PLL_Locked=1 -> DataBusWidth=16 and Div_Sel=01 three cycles after the request; Gate_En low 17 cycles; Width_Ack at request+19.
REQ-031 Width_Req with Req_Width=12 -> Width_Err pulse next cycle; DataBusWidth stays 8; Gate_En stays 1.
REQ-032 Width_Req with Req_Width=32 and TX_Idle held 0 -> Width_Err after 255 DRAIN cycles; width stays 8; Gate_En never falls.
REQ-033 Switch to 32; drop PLL_Locked for 5 cycles mid-SETTLE -> settle count restarts; Width_Ack arrives only after 16 consecutive locked cycles.
REQ-034 Assert Reset mid-SETTLE during an 8->32 switch -> next cycle DataBusWidth=8, Div_Sel=00, Gate_En=1, Busy=0, no Ack.
REQ-035 Width_Req=8 while at width 8 -> Width_Ack next cycle; Gate_En stays 1; a second Width_Req during a 16 switch is dropped.

Source files
------------

// File: rtl/phy_width_ctrl.sv
// phy_width_ctrl
// Controls PHY data-bus width changes. A request is checked, the TX path is
// drained, PCLK is gated, the new divider is applied, and PCLK stays gated
// until the Bit_CLK PLL has been locked for SETTLE_CYCLES consecutive cycles.
//
// Ports
//   CLK           in   single clock, rising edge
//   Reset         in   synchronous active-high reset
//   Width_Req     in   single-cycle width-change request strobe
//   Req_Width     in   [5:0] requested width, sampled with Width_Req
//   PLL_Locked    in   Bit_CLK PLL lock status
//   TX_Idle       in   TX datapath has no word in flight
//   DataBusWidth  out  [5:0] current width (8, 16 or 32)
//   Div_Sel       out  [1:0] PCLK divider (00=/1, 01=/2, 10=/4)
//   Gate_En       out  PCLK gate enable (1 = running)
//   Width_Ack     out  one-cycle pulse on successful completion
//   Width_Err     out  one-cycle pulse on rejected or timed-out request
//   Busy          out  high whenever the FSM is not IDLE
module phy_width_ctrl #(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       Width_Req,
    input  logic [5:0] Req_Width,
    input  logic       PLL_Locked,
    input  logic       TX_Idle,
    output logic [5:0] DataBusWidth,
    output logic [1:0] Div_Sel,
    output logic       Gate_En,
    output logic       Width_Ack,
    output logic       Width_Err,
    output logic       Busy
);

    localparam logic [7:0] SETTLE_LIM  = SETTLE_CYCLES[7:0];
    localparam logic [7:0] TIMEOUT_LIM = TIMEOUT_CYCLES[7:0];

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_GATE   = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    state_t     r_state;
    logic [5:0] r_req_width;
    logic [7:0] r_settle_cnt;
    logic [7:0] r_tmo_cnt;
    logic [5:0] r_width;
    logic [1:0] r_div;
    logic       r_gate;
    logic       r_ack;
    logic       r_err;
    logic       r_busy;

    state_t     w_state_nxt;
    logic [5:0] w_req_width_nxt;
    logic [7:0] w_settle_nxt;
    logic [7:0] w_tmo_nxt;
    logic [5:0] w_width_nxt;
    logic [1:0] w_div_nxt;
    logic       w_gate_nxt;
    logic       w_ack_nxt;
    logic       w_err_nxt;
    logic [7:0] w_settle_inc;
    logic [7:0] w_tmo_inc;

    function automatic logic width_valid(input logic [5:0] w);
        return (w == 6'd8) || (w == 6'd16) || (w == 6'd32);
    endfunction

    function automatic logic [1:0] div_for_width(input logic [5:0] w);
        logic [1:0] d;
        case (w)
            6'd16:   d = 2'b01;
            6'd32:   d = 2'b10;
            default: d = 2'b00;
        endcase
        return d;
    endfunction

    assign w_settle_inc = r_settle_cnt + 8'd1;
    assign w_tmo_inc    = r_tmo_cnt + 8'd1;

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        w_state_nxt     = r_state;
        w_req_width_nxt = r_req_width;
        w_settle_nxt    = r_settle_cnt;
        w_tmo_nxt       = r_tmo_cnt;
        w_width_nxt     = r_width;
        w_div_nxt       = r_div;
        w_gate_nxt      = r_gate;
        w_ack_nxt       = 1'b0;
        w_err_nxt       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Width_Req) begin
                    if (!width_valid(Req_Width) || !PLL_Locked) begin
                        w_err_nxt = 1'b1;
                    end else if (Req_Width == r_width) begin
                        w_ack_nxt  = 1'b1;
                        w_gate_nxt = 1'b1;
                    end else begin
                        w_req_width_nxt = Req_Width;
                        w_tmo_nxt       = 8'd0;
                        w_state_nxt     = ST_DRAIN;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (TX_Idle) begin
                    w_gate_nxt  = 1'b0;
                    w_state_nxt = ST_GATE;
                end else if (w_tmo_inc == TIMEOUT_LIM) begin
                    // Give up: configuration is left exactly as it was.
                    w_tmo_nxt   = w_tmo_inc;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_tmo_nxt = w_tmo_inc;
                end
            end
            ST_GATE: begin
                // PCLK is stopped, so the divider can change glitch-free here.
                w_width_nxt  = r_req_width;
                w_div_nxt    = div_for_width(r_req_width);
                w_settle_nxt = 8'd0;
                w_state_nxt  = ST_SETTLE;
            end
            ST_SETTLE: begin
                // Lock must be continuous; any unlocked cycle restarts the count.
                if (!PLL_Locked) begin
                    w_settle_nxt = 8'd0;
                end else if (w_settle_inc == SETTLE_LIM) begin
                    w_settle_nxt = w_settle_inc;
                    w_gate_nxt   = 1'b1;
                    w_ack_nxt    = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_settle_nxt = w_settle_inc;
                end
            end
            default: begin
                w_gate_nxt  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state      <= ST_IDLE;
            r_req_width  <= 6'd8;
            r_settle_cnt <= 8'd0;
            r_tmo_cnt    <= 8'd0;
            r_width      <= 6'd8;
            r_div        <= 2'b00;
            r_gate       <= 1'b1;
            r_ack        <= 1'b0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_req_width  <= w_req_width_nxt;
            r_settle_cnt <= w_settle_nxt;
            r_tmo_cnt    <= w_tmo_nxt;
            r_width      <= w_width_nxt;
            r_div        <= w_div_nxt;
            r_gate       <= w_gate_nxt;
            r_ack        <= w_ack_nxt;
            r_err        <= w_err_nxt;
            r_busy       <= (w_state_nxt != ST_IDLE);
        end
    end

    assign DataBusWidth = r_width;
    assign Div_Sel      = r_div;
    assign Gate_En      = r_gate;
    assign Width_Ack    = r_ack;
    assign Width_Err    = r_err;
    assign Busy         = r_busy;

endmodule

// File: tb/tb_phy_width_ctrl.sv
// Scoreboard bench for phy_width_ctrl: stimulus pushes the expected Ack/Err
// pulse (kind, cycle, width, divider) and a monitor pops it when a pulse shows.
module tb_phy_width_ctrl;

    logic       CLK = 1'b0;
    logic       Reset;
    logic       Width_Req;
    logic [5:0] Req_Width;
    logic       PLL_Locked;
    logic       TX_Idle;
    logic [5:0] DataBusWidth;
    logic [1:0] Div_Sel;
    logic       Gate_En;
    logic       Width_Ack;
    logic       Width_Err;
    logic       Busy;

    phy_width_ctrl #(.SETTLE_CYCLES(16), .TIMEOUT_CYCLES(255)) dut (
        .CLK(CLK), .Reset(Reset), .Width_Req(Width_Req), .Req_Width(Req_Width),
        .PLL_Locked(PLL_Locked), .TX_Idle(TX_Idle), .DataBusWidth(DataBusWidth),
        .Div_Sel(Div_Sel), .Gate_En(Gate_En), .Width_Ack(Width_Ack),
        .Width_Err(Width_Err), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int is_ack;
        int cyc;
        int w;
        int d;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc      = 0;
    int   gate_low = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    endtask

    task automatic push(input int is_ack, input int c, input int w, input int d);
        exp_t e;
        e.is_ack = is_ack; e.cyc = c; e.w = w; e.d = d;
        sb.push_back(e);
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [5:0] w);
        Width_Req = 1'b1;
        Req_Width = w;
        step(1);
        Width_Req = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 400) begin
            step(1);
            t++;
        end
        step(2);
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    // Monitor: compare each Ack/Err pulse with the oldest expectation.
    always @(negedge CLK) begin
        if (Width_Ack && Width_Err) begin
            chk("ack_err_exclusive", 1, 0);
        end else if (Width_Ack || Width_Err) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse_ack", int'(Width_Ack), 0);
            end else begin
                mon_e = sb.pop_front();
                chk("pulse_kind_ack", int'(Width_Ack), mon_e.is_ack);
                chk("pulse_cycle", cyc, mon_e.cyc);
                chk("pulse_width", int'(DataBusWidth), mon_e.w);
                chk("pulse_div", int'(Div_Sel), mon_e.d);
            end
        end
        if (!Gate_En) gate_low++;
    end

    initial begin
        Reset = 1'b1; Width_Req = 1'b0; Req_Width = 6'd8;
        PLL_Locked = 1'b1; TX_Idle = 1'b1;
        step(3);
        Reset = 1'b0;
        chk("rst_width", int'(DataBusWidth), 8);
        chk("rst_div", int'(Div_Sel), 0);
        chk("rst_gate", int'(Gate_En), 1);
        chk("rst_busy", int'(Busy), 0);
        chk("rst_ack", int'(Width_Ack), 0);
        chk("rst_err", int'(Width_Err), 0);

        // Same width: immediate ack, gate untouched.
        gate_low = 0; n = cyc;
        push(1, n + 1, 8, 0);
        issue(6'd8);
        drain();
        chk("same_gate_low", gate_low, 0);
        chk("same_busy", int'(Busy), 0);

        // Illegal width 12.
        n = cyc;
        push(0, n + 1, 8, 0);
        issue(6'd12);
        drain();
        chk("bad_width", int'(DataBusWidth), 8);
        chk("bad_gate", int'(Gate_En), 1);

        // Drain timeout with TX busy.
        TX_Idle = 1'b0; gate_low = 0; n = cyc;
        push(0, n + 256, 8, 0);
        issue(6'd32);
        step(2);
        chk("tmo_busy_mid", int'(Busy), 1);
        drain();
        chk("tmo_gate_low", gate_low, 0);
        chk("tmo_width", int'(DataBusWidth), 8);
        chk("tmo_div", int'(Div_Sel), 0);
        chk("tmo_busy_end", int'(Busy), 0);
        TX_Idle = 1'b1;

        // Clean 8 -> 16 switch, with a dropped request while busy.
        gate_low = 0; n = cyc;
        push(1, n + 19, 16, 1);
        issue(6'd16);
        step(1);
        chk("sw16_width_at2", int'(DataBusWidth), 8);
        chk("sw16_gate_at2", int'(Gate_En), 0);
        step(1);
        chk("sw16_width_at3", int'(DataBusWidth), 16);
        chk("sw16_div_at3", int'(Div_Sel), 1);
        step(2);
        issue(6'd32);
        drain();
        chk("sw16_gate_low", gate_low, 17);
        chk("sw16_width_end", int'(DataBusWidth), 16);

        // 16 -> 32 switch with PLL unlock for 5 cycles mid-settle.
        gate_low = 0; n = cyc;
        push(1, n + 31, 32, 2);
        issue(6'd32);
        step(9);
        PLL_Locked = 1'b0;
        step(5);
        PLL_Locked = 1'b1;
        drain();
        chk("drop_gate_low", gate_low, 29);
        chk("drop_div", int'(Div_Sel), 2);

        // Request while PLL unlocked is rejected.
        PLL_Locked = 1'b0; n = cyc;
        push(0, n + 1, 32, 2);
        issue(6'd16);
        PLL_Locked = 1'b1;
        drain();

        // Reset mid-settle during 8 -> 32 switch: no pulse at all.
        Reset = 1'b1; step(1); Reset = 1'b0;
        issue(6'd32);
        step(7);
        chk("mid_busy", int'(Busy), 1);
        Reset = 1'b1; step(1); Reset = 1'b0;
        chk("mid_rst_width", int'(DataBusWidth), 8);
        chk("mid_rst_div", int'(Div_Sel), 0);
        chk("mid_rst_gate", int'(Gate_En), 1);
        chk("mid_rst_busy", int'(Busy), 0);
        step(30);
        chk("mid_rst_no_pulse", sb.size(), 0);
        chk("mid_rst_width_end", int'(DataBusWidth), 8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
